// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI target endpoint.
// Mode 0 framing: clock idles low, data travels MSB first.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    RELOAD = 2'd2
  } spi_state_e;

  localparam int   DEFAULT_DATA_WIDTH  = 8;
  localparam int   DEFAULT_SYNC_STAGES = 2;
  localparam logic CPOL                = 1'b0;
  localparam logic MSB_FIRST           = 1'b1;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-stage synchroniser for one asynchronous SPI pin.
// Also produces single-cycle rise and fall pulses from the synchronised level.
module spi_pin_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;

  // Synchroniser chain plus one delayed copy of the level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {STAGES{RESET_VAL}};
      prev_r <= RESET_VAL;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], pin};
      prev_r <= sync_r[STAGES-1];
    end
  end

  assign level = sync_r[STAGES-1];
  assign rise  = level & ~prev_r;
  assign fall  = ~level & prev_r;

endmodule

// File: rtl/spi_target_core.sv
// SPI target endpoint: synchronised pins, MSB-first shift registers and a
// one-entry TX buffer that is consumed at every frame boundary.
module spi_target_core
  import spi_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int                    SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_error,
  output logic                  busy
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] WORD_ZERO = {DATA_WIDTH{1'b0}};

  logic sclk_level_unused_s, sclk_rise_s, sclk_fall_s;
  logic cs_level_s, cs_rise_s, cs_fall_s;
  logic mosi_s, mosi_rise_unused_s, mosi_fall_unused_s;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sclk (
    .clk(clk), .rst(rst), .pin(spi_sclk),
    .level(sclk_level_unused_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .pin(spi_cs_n),
    .level(cs_level_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .pin(spi_mosi),
    .level(mosi_s), .rise(mosi_rise_unused_s), .fall(mosi_fall_unused_s)
  );

  spi_state_e            state_r, state_nx;
  logic [CNT_W-1:0]      bit_cnt_r, bit_cnt_nx;
  logic [DATA_WIDTH-1:0] tx_shift_r, tx_shift_nx;
  logic [DATA_WIDTH-1:0] rx_shift_r, rx_shift_nx;
  logic [DATA_WIDTH-1:0] rx_data_r, rx_data_nx;
  logic [DATA_WIDTH-1:0] tx_buf_r, tx_buf_nx;
  logic                  tx_ready_r, tx_ready_nx;
  logic                  miso_r, miso_nx;
  logic                  rx_valid_r, rx_valid_nx;
  logic                  frame_error_r, frame_error_nx;
  logic                  consume_s;
  logic [DATA_WIDTH-1:0] tx_word_s;

  // An empty buffer at a frame boundary falls back to the default response.
  assign tx_word_s = tx_ready_r ? DEFAULT_TX : tx_buf_r;

  // Register every piece of state and every output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      bit_cnt_r     <= CNT_ZERO;
      tx_shift_r    <= WORD_ZERO;
      rx_shift_r    <= WORD_ZERO;
      rx_data_r     <= WORD_ZERO;
      tx_buf_r      <= WORD_ZERO;
      tx_ready_r    <= 1'b1;
      miso_r        <= 1'b0;
      rx_valid_r    <= 1'b0;
      frame_error_r <= 1'b0;
    end else begin
      state_r       <= state_nx;
      bit_cnt_r     <= bit_cnt_nx;
      tx_shift_r    <= tx_shift_nx;
      rx_shift_r    <= rx_shift_nx;
      rx_data_r     <= rx_data_nx;
      tx_buf_r      <= tx_buf_nx;
      tx_ready_r    <= tx_ready_nx;
      miso_r        <= miso_nx;
      rx_valid_r    <= rx_valid_nx;
      frame_error_r <= frame_error_nx;
    end
  end

  // Frame FSM and shift datapath; CS release outranks any SCLK edge.
  always_comb begin
    state_nx       = state_r;
    bit_cnt_nx     = bit_cnt_r;
    tx_shift_nx    = tx_shift_r;
    rx_shift_nx    = rx_shift_r;
    rx_data_nx     = rx_data_r;
    miso_nx        = miso_r;
    rx_valid_nx    = 1'b0;
    frame_error_nx = 1'b0;
    consume_s      = 1'b0;
    if (cs_rise_s) begin
      state_nx    = IDLE;
      miso_nx     = 1'b0;
      bit_cnt_nx  = CNT_ZERO;
      rx_shift_nx = WORD_ZERO;
      if ((state_r == SHIFT) && (bit_cnt_r != CNT_ZERO)) begin
        frame_error_nx = 1'b1;
      end else begin
        frame_error_nx = 1'b0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          bit_cnt_nx = CNT_ZERO;
          miso_nx    = 1'b0;
          if (cs_fall_s) begin
            consume_s   = 1'b1;
            tx_shift_nx = tx_word_s;
            miso_nx     = tx_word_s[DATA_WIDTH-1];
            state_nx    = SHIFT;
          end else begin
            state_nx = IDLE;
          end
        end
        SHIFT: begin
          if (sclk_rise_s) begin
            rx_shift_nx = {rx_shift_r[DATA_WIDTH-2:0], mosi_s};
            if (bit_cnt_r == CNT_LAST) begin
              rx_data_nx  = {rx_shift_r[DATA_WIDTH-2:0], mosi_s};
              rx_valid_nx = 1'b1;
              bit_cnt_nx  = CNT_ZERO;
              state_nx    = RELOAD;
            end else begin
              bit_cnt_nx = bit_cnt_r + CNT_W'(1);
            end
          end else if (sclk_fall_s) begin
            tx_shift_nx = {tx_shift_r[DATA_WIDTH-2:0], 1'b0};
            miso_nx     = tx_shift_r[DATA_WIDTH-2];
          end else begin
            state_nx = SHIFT;
          end
        end
        RELOAD: begin
          if (sclk_fall_s) begin
            consume_s   = 1'b1;
            tx_shift_nx = tx_word_s;
            miso_nx     = tx_word_s[DATA_WIDTH-1];
            state_nx    = SHIFT;
          end else begin
            state_nx = RELOAD;
          end
        end
        default: begin
          state_nx   = IDLE;
          bit_cnt_nx = CNT_ZERO;
          miso_nx    = 1'b0;
        end
      endcase
    end
  end

  // TX buffer: a consume empties it, a load is accepted only into an empty
  // buffer, so a load racing a consume of an empty buffer survives it.
  always_comb begin
    tx_buf_nx   = tx_buf_r;
    tx_ready_nx = tx_ready_r;
    if (consume_s) begin
      tx_ready_nx = 1'b1;
    end else begin
      tx_ready_nx = tx_ready_r;
    end
    if (tx_load && tx_ready_r) begin
      tx_buf_nx   = tx_data;
      tx_ready_nx = 1'b0;
    end else begin
      tx_buf_nx = tx_buf_r;
    end
  end

  assign spi_miso    = miso_r;
  assign tx_ready    = tx_ready_r;
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign frame_error = frame_error_r;
  assign busy        = ~cs_level_s;

endmodule

// File: tb/tb_spi_target_core.sv
// Self-checking bench for spi_target_core: a bit-banged SPI host plus a
// behavioural model of the one-entry TX buffer and the expected RX words.
module tb_spi_target_core;

  localparam int HALF = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       spi_sclk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       busy;

  spi_target_core dut (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .tx_data(tx_data),
    .tx_load(tx_load), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_error(frame_error), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails = 0;

  // Monitor state
  int         cyc = 0;
  int         last_rise_cyc = 0;
  int         rx_lat = -1;
  int         wide_pulse = 0;
  int         fe_cnt = 0;
  logic       rx_valid_prev = 1'b0;
  logic [7:0] rx_q[$];

  // Model of the TX buffer
  logic       m_full = 1'b0;
  logic [7:0] m_buf = 8'h00;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_q.push_back(rx_data);
      rx_lat = cyc - last_rise_cyc;
      if (rx_valid_prev) wide_pulse++;
    end
    if (frame_error) fe_cnt++;
    rx_valid_prev = rx_valid;
  end

  function automatic logic [7:0] model_take();
    logic [7:0] w;
    w = m_full ? m_buf : 8'hA5;
    m_full = 1'b0;
    return w;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] w);
    tx_data = w;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    if (!m_full) begin
      m_buf  = w;
      m_full = 1'b1;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic cs_high();
    wait_clks(HALF);
    spi_cs_n = 1'b1;
    wait_clks(HALF);
  endtask

  task automatic host_xfer(input logic [7:0] mosi_w, input int nbits, output logic [7:0] miso_w);
    miso_w = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mosi_w[7-i];
      wait_clks(HALF);
      miso_w[7-i] = spi_miso;
      spi_sclk = 1'b1;
      last_rise_cyc = cyc;
      wait_clks(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(1);
    tests_run++; if (spi_miso !== 1'b0) begin fails++; $display("FAIL reset_miso got %b want 0", spi_miso); end
    tests_run++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
    tests_run++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    tests_run++; if (frame_error !== 1'b0) begin fails++; $display("FAIL reset_frame_error got %b want 0", frame_error); end
    tests_run++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL reset_tx_ready got %b want 1", tx_ready); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    logic [7:0] m, e;
    rx_q.delete();
    cs_low();
    tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy got %b want 1", busy); end
    e = model_take();
    host_xfer(8'h3C, 8, m);
    e = e; void'(model_take());
    cs_high();
    tests_run++; if (m !== e) begin fails++; $display("FAIL basic_miso got %h want %h", m, e); end
    tests_run++; if (rx_q.size() !== 1) begin fails++; $display("FAIL basic_rx_count got %0d want 1", rx_q.size()); end
    else if (rx_q[0] !== 8'h3C) begin fails++; $display("FAIL basic_rx_data got %h want 3c", rx_q[0]); end
    tests_run++; if (rx_lat !== 3) begin fails++; $display("FAIL basic_rx_latency got %0d want 3", rx_lat); end
    tests_run++; if (wide_pulse !== 0) begin fails++; $display("FAIL basic_rx_pulse_width got %0d wide pulses want 0", wide_pulse); end
  endtask

  task automatic test_loaded();
    logic [7:0] m, e;
    rx_q.delete();
    do_load(8'h96);
    tests_run++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL loaded_ready_drop got %b want 0", tx_ready); end
    cs_low();
    e = model_take();
    tests_run++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL loaded_ready_rise got %b want 1", tx_ready); end
    host_xfer(8'hF0, 8, m);
    void'(model_take());
    cs_high();
    tests_run++; if (m !== e) begin fails++; $display("FAIL loaded_miso got %h want %h", m, e); end
    tests_run++; if (rx_q.size() !== 1) begin fails++; $display("FAIL loaded_rx_count got %0d want 1", rx_q.size()); end
    else if (rx_q[0] !== 8'hF0) begin fails++; $display("FAIL loaded_rx_data got %h want f0", rx_q[0]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] m0, m1, e0, e1;
    rx_q.delete();
    cs_low();
    e0 = model_take();
    do_load(8'h55);
    host_xfer(8'h12, 8, m0);
    e1 = model_take();
    host_xfer(8'h34, 8, m1);
    void'(model_take());
    cs_high();
    tests_run++; if (m0 !== e0) begin fails++; $display("FAIL b2b_miso0 got %h want %h", m0, e0); end
    tests_run++; if (m1 !== e1) begin fails++; $display("FAIL b2b_miso1 got %h want %h", m1, e1); end
    tests_run++; if (rx_q.size() !== 2) begin fails++; $display("FAIL b2b_rx_count got %0d want 2", rx_q.size()); end
    else if (rx_q[0] !== 8'h12 || rx_q[1] !== 8'h34) begin
      fails++; $display("FAIL b2b_rx_data got %h %h want 12 34", rx_q[0], rx_q[1]);
    end
  endtask

  task automatic test_frame_error();
    logic [7:0] m, saved;
    int fe0;
    rx_q.delete();
    saved = rx_data;
    fe0 = fe_cnt;
    do_load(8'hFF);
    cs_low();
    void'(model_take());
    host_xfer(8'($urandom), 5, m);
    wait_clks(HALF);
    tests_run++; if (spi_miso !== 1'b1) begin fails++; $display("FAIL ferr_miso_before got %b want 1", spi_miso); end
    spi_cs_n = 1'b1;
    wait_clks(3);
    tests_run++; if (spi_miso !== 1'b0) begin fails++; $display("FAIL ferr_miso_idle got %b want 0", spi_miso); end
    wait_clks(10);
    tests_run++; if (fe_cnt !== fe0 + 1) begin fails++; $display("FAIL ferr_pulses got %0d want %0d", fe_cnt - fe0, 1); end
    tests_run++; if (rx_q.size() !== 0) begin fails++; $display("FAIL ferr_rx_count got %0d want 0", rx_q.size()); end
    tests_run++; if (rx_data !== saved) begin fails++; $display("FAIL ferr_rx_data got %h want %h", rx_data, saved); end
  endtask

  task automatic test_load_ignored();
    logic [7:0] m, e;
    rx_q.delete();
    do_load(8'h11);
    do_load(8'h22);
    tests_run++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL ignore_ready got %b want 0", tx_ready); end
    cs_low();
    e = model_take();
    host_xfer(8'h5A, 8, m);
    void'(model_take());
    cs_high();
    tests_run++; if (m !== e) begin fails++; $display("FAIL ignore_miso got %h want %h", m, e); end
    tests_run++; if (rx_data !== 8'h5A) begin fails++; $display("FAIL ignore_rx_data got %h want 5a", rx_data); end
  endtask

  task automatic test_simul_load();
    logic [7:0] m, e, w;
    w = 8'($urandom_range(255, 1));
    spi_cs_n = 1'b0;
    wait_clks(2);
    tx_data = w;
    tx_load = 1'b1;
    wait_clks(1);
    tx_load = 1'b0;
    e = model_take();
    m_buf = w;
    m_full = 1'b1;
    wait_clks(HALF - 3);
    tests_run++; if (tx_ready !== !m_full) begin fails++; $display("FAIL simul_ready got %b want %b", tx_ready, !m_full); end
    host_xfer(8'($urandom), 8, m);
    void'(model_take());
    cs_high();
    tests_run++; if (m !== e) begin fails++; $display("FAIL simul_miso got %h want %h", m, e); end
  endtask

  task automatic test_random();
    logic [7:0] m, e, w;
    logic [7:0] exp_q[$];
    int n;
    for (int it = 0; it < 6; it++) begin
      rx_q.delete();
      exp_q.delete();
      if ($urandom_range(1, 0) == 1) do_load(8'($urandom));
      cs_low();
      e = model_take();
      n = $urandom_range(2, 1);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(1, 0) == 1) do_load(8'($urandom));
        w = 8'($urandom);
        host_xfer(w, 8, m);
        exp_q.push_back(w);
        tests_run++; if (m !== e) begin fails++; $display("FAIL random_miso it%0d w%0d got %h want %h", it, k, m, e); end
        e = model_take();
      end
      cs_high();
      tests_run++; if (rx_q.size() !== exp_q.size()) begin
        fails++; $display("FAIL random_rx_count it%0d got %0d want %0d", it, rx_q.size(), exp_q.size());
      end else if (rx_q != exp_q) begin
        fails++; $display("FAIL random_rx_data it%0d got %h want %h", it, rx_q[rx_q.size()-1], exp_q[exp_q.size()-1]);
      end
      tests_run++; if (tx_ready !== !m_full) begin fails++; $display("FAIL random_ready it%0d got %b want %b", it, tx_ready, !m_full); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] m, e;
    int fe0;
    rx_q.delete();
    fe0 = fe_cnt;
    cs_low();
    void'(model_take());
    do_load(8'h77);
    host_xfer(8'hE7, 4, m);
    rst = 1'b1;
    wait_clks(1);
    tests_run++; if (spi_miso !== 1'b0 || rx_data !== 8'h00 || rx_valid !== 1'b0 || frame_error !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midrst_outputs got miso=%b rx=%h v=%b fe=%b rdy=%b busy=%b want 0 00 0 0 1 0",
               spi_miso, rx_data, rx_valid, frame_error, tx_ready, busy);
    end
    spi_cs_n = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    m_full = 1'b0;
    wait_clks(8);
    tests_run++; if (fe_cnt !== fe0 || rx_q.size() !== 0) begin
      fails++; $display("FAIL midrst_no_pulse got fe=%0d rx=%0d want 0 0", fe_cnt - fe0, rx_q.size());
    end
    cs_low();
    e = model_take();
    host_xfer(8'hC3, 8, m);
    void'(model_take());
    cs_high();
    tests_run++; if (m !== e) begin fails++; $display("FAIL midrst_miso got %h want %h", m, e); end
    tests_run++; if (rx_q.size() !== 1) begin fails++; $display("FAIL midrst_rx_count got %0d want 1", rx_q.size()); end
    else if (rx_q[0] !== 8'hC3) begin fails++; $display("FAIL midrst_rx_data got %h want c3", rx_q[0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_loaded();
    test_back_to_back();
    test_frame_error();
    test_load_ignored();
    test_simul_load();
    test_random();
    test_reset_mid();
    tests_run++; if (wide_pulse !== 0) begin fails++; $display("FAIL rx_valid_width got %0d wide pulses want 0", wide_pulse); end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/spi_target_core.md
# spi_target_core

SPI target (slave) endpoint for the opposite end of the link driven by the team's SPI host: one frame of DATA_WIDTH bits per transfer, MSB first, CPOL=0. The SPI pins are sampled asynchronously, synchronised into `clk`, and edge-detected. Each received word is delivered on a parallel port with a one-cycle valid strobe. A one-entry transmit buffer supplies the word returned on MISO.

## Interface
- DATA_WIDTH, 8: frame width in bits (≥2)
- SYNC_STAGES, 2: flip-flop stages on each SPI input (≥2)
- DEFAULT_TX, 8'hA5: word returned when the TX buffer is empty at frame start

- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- spi_sclk  in  1  SPI clock from host
- spi_cs_n  in  1  chip select, active-low
- spi_mosi  in  1  host → target data
- spi_miso  out  1  target → host data
- tx_data  in  DATA_WIDTH  next response word
- tx_load  in  1  write tx_data into TX buffer (accepted only when tx_ready=1)
- tx_ready  out  1  TX buffer empty
- rx_data  out  DATA_WIDTH  last complete received word
- rx_valid  out  1  one-cycle strobe, rx_data updated
- frame_error  out  1  one-cycle strobe, CS released mid-frame
- busy  out  1  CS asserted (synchronised)

## Operation
- Synchroniser reset values: sclk=0, cs_n=1, mosi=0.
- Edges are derived from the last two synchronised samples:
  - sclk_rise, sclk_fall
  - cs_fall, cs_rise
- States:
  - IDLE: spi_miso=0, bit_cnt=0.
    - On cs_fall, load tx_shift from the TX buffer, or DEFAULT_TX if it is empty. Drive tx_shift MSB on spi_miso.
    - Mark the buffer empty (tx_ready=1). Go to SHIFT.
  - SHIFT, on sclk_rise:
    - rx_shift ← {rx_shift[DATA_WIDTH-2:0], mosi}; bit_cnt++.
    - When bit_cnt reaches DATA_WIDTH-1, the same cycle writes rx_data ← completed word, pulses rx_valid, clears bit_cnt and goes to RELOAD.
  - SHIFT, on sclk_fall: shift tx_shift left and drive the new MSB on spi_miso.
  - RELOAD: the next sclk_fall reloads tx_shift from the buffer (or DEFAULT_TX) and drives its MSB, then returns to SHIFT. This supports back-to-back frames under one CS.
  - Any state, on cs_rise: go to IDLE and set spi_miso=0.
    - If in SHIFT with bit_cnt≠0, pulse frame_error and discard the partial rx_shift; rx_data is unchanged.
- TX buffer:
  - tx_load with tx_ready=1 stores the word and drops tx_ready.
  - tx_load with tx_ready=0 is ignored; the buffer is not overwritten.
- Simultaneous tx_load and buffer consume while empty: the frame uses DEFAULT_TX and the loaded word stays in the buffer, so tx_ready=0.
- cs_rise has priority over sclk edges in the same cycle.
- rst mid-frame: all state returns to reset values next cycle; no frame_error or rx_valid pulse.
- busy = synchronised cs_n inverted.

## Timing
- Output reset values:
  - spi_miso=0
  - rx_data=0
  - rx_valid=0
  - frame_error=0
  - tx_ready=1
  - busy=0
- Pin-to-action latency is SYNC_STAGES+1 clk cycles (3 by default). This applies to:
  - a pin edge to its state update;
  - MISO after SCLK falling or CS falling.
- rx_valid asserts SYNC_STAGES+1 cycles after the final SCLK rising edge, for exactly 1 cycle.
- Required SCLK high and low time: ≥ SYNC_STAGES+2 clk cycles. Host CLK_DIV=16 gives 16 and meets this.
- CS setup to the first SCLK rise: ≥ SYNC_STAGES+2 clk cycles, so the MISO MSB is valid before the host samples it.
- Frames are fully pipelined; there is no dead cycle between frames inside one CS.

## Structure
- spi_pkg:
  - state enum {IDLE, SHIFT, RELOAD};
  - default width and polarity constants (CPOL=0, MSB_FIRST=1).
- Sub-module spi_pin_sync:
  - SYNC_STAGES flip-flop chain, reset value as a parameter;
  - outputs level, rise and fall.
  - Instantiated for sclk and cs_n; mosi uses the level output only.
- Top: FSM, bit counter ($clog2(DATA_WIDTH) bits), tx_shift, rx_shift, TX buffer and its valid flag.

## Test plan
- Reset, then one frame with MOSI=8'h3C and TX buffer empty, CLK_DIV=16 → rx_data=8'h3C with one rx_valid pulse; host sees MISO=8'hA5.
- tx_load 8'h96, then a frame with MOSI=8'hF0 → MISO=8'h96, rx_data=8'hF0; tx_ready drops on load and rises at cs_fall.
- Two frames under one CS, MOSI 8'h12 then 8'h34, buffer reloaded with 8'h55 between them → two rx_valid pulses (8'h12, 8'h34); second MISO word is 8'h55.
- CS released after 5 bits → one frame_error pulse, no rx_valid, rx_data unchanged, spi_miso=0 within 3 cycles.
- tx_load while tx_ready=0 (first 8'h11, then 8'h22) → next frame returns 8'h11.
- rst asserted mid-frame at bit 4 → all outputs at reset values next cycle; a following full frame of 8'hC3 is received correctly.
